// File: rtl/bp_pht_if.sv
// Bundle of prediction and update signals between the requesters and
// bp_pht_ctrl.
//
// Handshake rules:
// - A prediction is accepted on a rising edge where pred_valid && pred_ready.
//   Its result appears one cycle later with pred_resp_valid high for one cycle.
// - An update is accepted on a rising edge where upd_valid && upd_ready.
//   Requesters may change idx/taken freely while valid is low.
interface bp_pht_if #(
  parameter int IDX_W = 4
);
  logic             pred_valid;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_ready;
  logic             pred_resp_valid;
  logic             pred_taken;
  logic [1:0]       pred_state;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic             busy;

  // Requester side: fetch and branch-resolve.
  modport master (
    output pred_valid, pred_idx, upd_valid, upd_idx, upd_taken,
    input  pred_ready, pred_resp_valid, pred_taken, pred_state, upd_ready, busy
  );

  // Controller side.
  modport slave (
    input  pred_valid, pred_idx, upd_valid, upd_idx, upd_taken,
    output pred_ready, pred_resp_valid, pred_taken, pred_state, upd_ready, busy
  );
endinterface

// File: rtl/bp_pht_ctrl.sv
// Pattern history table controller.
//
// The table holds 2**IDX_W two-bit saturating counters.
// After reset, an init sweep writes INIT_VAL to every entry. The controller
// then serves one prediction read per cycle. Resolved-branch updates go into a
// QDEPTH-entry FIFO, and one update is committed on every cycle in which the
// FIFO is non-empty.
//
// Optional macro BP_PHT_BYPASS_EN: when defined, a prediction that reads the
// entry being committed on the same edge returns the post-commit value.
// Without it, the prediction returns the pre-write value.
//
// dbg_run exposes the FSM state: 0 = INIT sweep, 1 = RUN.
module bp_pht_ctrl #(
  parameter int         IDX_W    = 4,
  parameter int         QDEPTH   = 2,
  parameter logic [1:0] INIT_VAL = 2'b01
) (
  input  logic    clk,
  input  logic    reset,
  bp_pht_if.slave bus,
  output logic    dbg_run
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int CNT_W   = 3;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] q_idx_q [QDEPTH];
  logic [IDX_W-1:0] q_idx_d [QDEPTH];
  logic             q_tkn_q [QDEPTH];
  logic             q_tkn_d [QDEPTH];
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       pred_state_q, pred_state_d;
  logic [1:0]       table_q [ENTRIES];

  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [1:0]       tbl_wdata;
  logic             is_run, pop, pred_acc, upd_acc, upd_ready;
  logic [1:0]       head_val, commit_val, pred_rd;
  logic [CNT_W-1:0] wpos;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    else       return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
  endfunction

  assign is_run     = (state_q == ST_RUN);
  assign pop        = is_run && (count_q != '0);
  assign upd_ready  = is_run && (count_q < CNT_W'(QDEPTH));
  assign pred_acc   = bus.pred_valid && is_run;
  assign upd_acc    = bus.upd_valid && upd_ready;
  assign head_val   = table_q[q_idx_q[0]];
  assign commit_val = sat_next(head_val, q_tkn_q[0]);

  // Prediction read value, optionally forwarded from the commit on this edge.
  always_comb begin
    pred_rd = table_q[bus.pred_idx];
`ifdef BP_PHT_BYPASS_EN
    if (pop && (q_idx_q[0] == bus.pred_idx)) pred_rd = commit_val;
`endif
  end

  // Next state: init sweep, FIFO push/pop, table write port, prediction capture.
  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    count_d      = count_q;
    q_idx_d      = q_idx_q;
    q_tkn_d      = q_tkn_q;
    resp_valid_d = 1'b0;
    pred_state_d = pred_state_q;
    tbl_we       = 1'b0;
    tbl_waddr    = init_idx_q;
    tbl_wdata    = INIT_VAL;
    // Slot where a new entry lands, after the head shifts out on a pop.
    wpos         = count_q - CNT_W'(pop);
    if (!is_run) begin
      tbl_we     = 1'b1;
      init_idx_d = init_idx_q + IDX_W'(1);
      if (init_idx_q == IDX_W'(ENTRIES - 1)) state_d = ST_RUN;
    end else begin
      if (pop) begin
        tbl_we    = 1'b1;
        tbl_waddr = q_idx_q[0];
        tbl_wdata = commit_val;
        for (int i = 0; i < QDEPTH - 1; i++) begin
          q_idx_d[i] = q_idx_q[i+1];
          q_tkn_d[i] = q_tkn_q[i+1];
        end
      end
      if (upd_acc) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (CNT_W'(i) == wpos) begin
            q_idx_d[i] = bus.upd_idx;
            q_tkn_d[i] = bus.upd_taken;
          end
        end
      end
      count_d = count_q + CNT_W'(upd_acc) - CNT_W'(pop);
      if (pred_acc) begin
        resp_valid_d = 1'b1;
        pred_state_d = pred_rd;
      end
    end
  end

  // FSM and control registers. Reset takes priority over every request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_idx_q   <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      pred_state_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      pred_state_q <= pred_state_d;
    end
    q_idx_q <= q_idx_d;
    q_tkn_q <= q_tkn_d;
  end

  // Single write port of the counter table. The write is blocked during reset.
  always_ff @(posedge clk) begin
    if (!reset && tbl_we) table_q[tbl_waddr] <= tbl_wdata;
  end

  assign bus.pred_ready      = is_run;
  assign bus.upd_ready       = upd_ready;
  assign bus.busy            = !is_run;
  assign bus.pred_resp_valid = resp_valid_q;
  assign bus.pred_state      = pred_state_q;
  assign bus.pred_taken      = pred_state_q[1];
  assign dbg_run             = is_run;
endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Testbench for bp_pht_ctrl.
// It runs directed scenarios, then a randomized phase.
// Outputs are compared against a counter-table model that uses integer
// arithmetic and a FIFO of pending updates.
module tb_bp_pht_ctrl;
  localparam int IDX_W    = 4;
  localparam int QDEPTH   = 2;
  localparam int ENTRIES  = 16;
  localparam int INIT_VAL = 1;

  logic clk = 1'b0;
  logic reset;
  logic dbg_run;

  bp_pht_if #(.IDX_W(IDX_W)) bus ();

  bp_pht_ctrl #(.IDX_W(IDX_W), .QDEPTH(QDEPTH), .INIT_VAL(2'b01)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_run(dbg_run)
  );

  // Clock.
  always #5 clk = ~clk;

  // Check counters and the checking task.
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model.
  int         m_tbl [ENTRIES];
  int         init_left;
  int         init_ptr;
  int         uq_idx [$];
  bit         uq_t [$];
  bit         m_resp_valid;
  int         m_state;
  logic [1:0] exp_q [$];
  bit         obs_valid;
  int         obs_state;

  function automatic int sat(input int v, input bit t);
    if (t) return (v + 1 > 3) ? 3 : v + 1;
    return (v - 1 < 0) ? 0 : v - 1;
  endfunction

  // Advance the model and the DUT by one edge, then compare every output.
  task automatic step();
    bit run;
    bit can_push;
    int pred_before;
    int ci;
    bit ct;
    run = (init_left == 0);
    if (reset) begin
      uq_idx.delete();
      uq_t.delete();
      exp_q.delete();
      init_left    = ENTRIES;
      init_ptr     = 0;
      m_resp_valid = 0;
      m_state      = 0;
    end else if (!run) begin
      m_tbl[init_ptr] = INIT_VAL;
      init_ptr++;
      init_left--;
      m_resp_valid = 0;
    end else begin
      can_push     = uq_idx.size() < QDEPTH;
      pred_before  = m_tbl[bus.pred_idx];
      m_resp_valid = bus.pred_valid;
      if (uq_idx.size() > 0) begin
        ci = uq_idx.pop_front();
        ct = uq_t.pop_front();
        m_tbl[ci] = sat(m_tbl[ci], ct);
      end
      if (bus.pred_valid) begin
`ifdef BP_PHT_BYPASS_EN
        m_state = m_tbl[bus.pred_idx];
`else
        m_state = pred_before;
`endif
        exp_q.push_back(2'(m_state));
      end
      if (bus.upd_valid && can_push) begin
        uq_idx.push_back(int'(bus.upd_idx));
        uq_t.push_back(bus.upd_taken);
      end
    end
    @(posedge clk);
    #1;
    run = (init_left == 0);
    check("busy", int'(bus.busy), int'(!run));
    check("dbg_run", int'(dbg_run), int'(run));
    check("pred_ready", int'(bus.pred_ready), int'(run));
    check("upd_ready", int'(bus.upd_ready), int'(run && (uq_idx.size() < QDEPTH)));
    check("resp_valid", int'(bus.pred_resp_valid), int'(m_resp_valid));
    check("pred_state_hold", int'(bus.pred_state), m_state);
    check("pred_taken", int'(bus.pred_taken), m_state / 2);
    if (m_resp_valid) begin
      if (exp_q.size() == 0) check("exp_q_underflow", 1, 0);
      else check("resp_state", int'(bus.pred_state), int'(exp_q.pop_front()));
    end
    obs_valid = bus.pred_resp_valid;
    obs_state = int'(bus.pred_state);
  endtask

  // Driver tasks.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic predict(input int idx, output int st);
    bus.pred_valid = 1'b1;
    bus.pred_idx   = IDX_W'(idx);
    step();
    bus.pred_valid = 1'b0;
    st = obs_state;
  endtask

  task automatic update(input int idx, input bit t);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = IDX_W'(idx);
    bus.upd_taken = t;
    step();
    bus.upd_valid = 1'b0;
  endtask

  task automatic release_reset(input string tag);
    int n;
    n = 0;
    reset = 1'b0;
    while (bus.busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    check(tag, n, ENTRIES);
  endtask

  // Stimulus.
  initial begin
    int st;
    reset          = 1'b1;
    bus.pred_valid = 1'b0;
    bus.pred_idx   = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_idx    = '0;
    bus.upd_taken  = 1'b0;
    init_left      = ENTRIES;
    init_ptr       = 0;
    m_state        = 0;
    m_resp_valid   = 0;
    for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 0;

    // Reset for two cycles, then the init sweep.
    idle(2);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_state", int'(bus.pred_state), 0);
    release_reset("init_len");
    for (int i = 0; i < ENTRIES; i++) begin
      predict(i, st);
      check("init_val", st, 1);
    end

    // Back-to-back predictions after training idx 2.
    update(2, 1'b1);
    update(2, 1'b1);
    idle(2);
    bus.pred_valid = 1'b1;
    bus.pred_idx   = 4'd1; step(); check("b2b_v0", int'(obs_valid), 1); check("b2b_s0", obs_state, 1);
    bus.pred_idx   = 4'd2; step(); check("b2b_v1", int'(obs_valid), 1); check("b2b_s1", obs_state, 3);
    bus.pred_idx   = 4'd3; step(); check("b2b_v2", int'(obs_valid), 1); check("b2b_s2", obs_state, 1);
    bus.pred_valid = 1'b0;
    idle(1);

    // Saturation on idx 5.
    for (int i = 0; i < 3; i++) update(5, 1'b1);
    idle(2);
    predict(5, st); check("sat_up", st, 3);
    for (int i = 0; i < 4; i++) update(5, 1'b0);
    idle(2);
    predict(5, st); check("sat_dn", st, 0);
    update(5, 1'b0);
    idle(2);
    predict(5, st); check("sat_floor", st, 0);

    // upd_valid held high for four cycles on idx 3.
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 4'd3;
    bus.upd_taken = 1'b1;
    idle(4);
    bus.upd_valid = 1'b0;
    idle(3);
    predict(3, st); check("bp_final", st, 3);

    // Same-edge collision on idx 7.
    update(7, 1'b1);
    predict(7, st);
`ifdef BP_PHT_BYPASS_EN
    check("collision", st, 2);
`else
    check("collision", st, 1);
`endif
    idle(1);
    predict(7, st); check("collision_after", st, 2);

    // Reset while an update to idx 9 is pending.
    update(9, 1'b1);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 4'd9;
    bus.upd_taken = 1'b1;
    reset = 1'b1;
    step();
    bus.upd_valid = 1'b0;
    release_reset("reinit_len");
    predict(9, st); check("reset_flush", st, 1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      bus.pred_valid = 1'($urandom_range(0, 1));
      bus.pred_idx   = IDX_W'($urandom_range(0, ENTRIES - 1));
      bus.upd_valid  = ($urandom_range(0, 3) != 0);
      bus.upd_idx    = IDX_W'($urandom_range(0, 7));
      bus.upd_taken  = 1'($urandom_range(0, 1));
      reset          = ($urandom_range(0, 199) == 0);
      step();
    end
    reset          = 1'b0;
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
    idle(20);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
